// File: rtl/datapath_pkg.sv
// Shared types for the sequenced bus datapath: sequencer states, mode codes
// and bus-source selection.
package datapath_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_TA, S_TB, S_TWB, S_THI, S_TMAR, S_TWAIT, S_TMDR
  } state_t;

  localparam logic [1:0] MODE_ALU  = 2'd0;
  localparam logic [1:0] MODE_WIDE = 2'd1;
  localparam logic [1:0] MODE_LOAD = 2'd2;
  localparam logic [1:0] MODE_ILL  = 2'd3;

  typedef enum logic [2:0] {
    BUS_NONE, BUS_REG, BUS_ZLO, BUS_ZHI, BUS_MDR
  } bus_sel_t;

  // Exactly one driver per state; TA/TB/TMAR all read through the register port.
  function automatic bus_sel_t bus_source(input state_t s);
    case (s)
      S_TA, S_TB, S_TMAR: return BUS_REG;
      S_TWB:              return BUS_ZLO;
      S_THI:              return BUS_ZHI;
      S_TMDR:             return BUS_MDR;
      default:            return BUS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// General register file: one write port, bus and debug read ports.
// SEQ_DATAPATH_R0_ZERO_EN makes R0 a hard-wired zero.
module dp_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [RW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             write_ok;

`ifdef SEQ_DATAPATH_R0_ZERO_EN
  assign write_ok = (waddr != '0);
  assign rdata    = (raddr == '0) ? '0 : regs[raddr];
  assign dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];
`else
  assign write_ok = 1'b1;
  assign rdata    = regs[raddr];
  assign dbg_data = regs[dbg_sel];
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && write_ok) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/seq_datapath.sv
// Bus-based datapath with a micro-step sequencer for ALU, wide-ALU and load
// sequences. Optional hard-zero R0 via SEQ_DATAPATH_R0_ZERO_EN (in dp_regfile).
module seq_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int OPW   = 5,
  localparam int RW = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [OPW-1:0]     op,
  input  logic [RW-1:0]      ra,
  input  logic [RW-1:0]      rb,
  input  logic [RW-1:0]      rd,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [2*WIDTH-1:0] alu_c,
  output logic               mem_rd_req,
  output logic [WIDTH-1:0]   mem_addr,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ready,
  input  logic [RW-1:0]      dbg_sel,
  output logic [WIDTH-1:0]   dbg_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_t             state;
  logic [1:0]         mode_q;
  logic [OPW-1:0]     op_q;
  logic [RW-1:0]      ra_q, rb_q, rd_q;
  logic [WIDTH-1:0]   y, mar, mdr, hi_q, lo_q;
  logic [2*WIDTH-1:0] z;
  logic               done_q, err_q, ill_pend;
  logic [WIDTH-1:0]   bus, rf_rdata;
  logic [RW-1:0]      rf_raddr;
  logic               rf_we;

  assign rf_raddr = (state == S_TA) ? ra_q : rb_q;
  assign rf_we    = (state == S_TWB && mode_q == MODE_ALU) || (state == S_TMDR);

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .clr      (clr),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (bus),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_comb begin
    bus = '0;
    case (bus_source(state))
      BUS_REG: bus = rf_rdata;
      BUS_ZLO: bus = z[WIDTH-1:0];
      BUS_ZHI: bus = z[2*WIDTH-1:WIDTH];
      BUS_MDR: bus = mdr;
      default: bus = '0;
    endcase
  end

  // An illegal mode stays in IDLE; ill_pend delays its done by one cycle so
  // it lands one cycle after the accepting edge like the other sequences.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      y        <= '0;
      z        <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mar      <= '0;
      mdr      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ill_pend <= 1'b0;
    end else begin
      done_q   <= ill_pend;
      ill_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            op_q   <= op;
            ra_q   <= ra;
            rb_q   <= rb;
            rd_q   <= rd;
            err_q  <= (mode == MODE_ILL);
            case (mode)
              MODE_ALU, MODE_WIDE: state <= S_TA;
              MODE_LOAD:           state <= S_TMAR;
              default:             ill_pend <= 1'b1;
            endcase
          end
        end
        S_TA: begin
          y     <= bus;
          state <= S_TB;
        end
        S_TB: begin
          z     <= alu_c;
          state <= S_TWB;
        end
        S_TWB: begin
          if (mode_q == MODE_WIDE) begin
            lo_q  <= bus;
            state <= S_THI;
          end else begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_THI: begin
          hi_q   <= bus;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        S_TMAR: begin
          mar   <= bus;
          state <= S_TWAIT;
        end
        S_TWAIT: begin
          if (mem_ready) begin
            mdr   <= mem_rdata;
            state <= S_TMDR;
          end
        end
        S_TMDR: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign alu_a      = y;
  assign alu_b      = bus;
  assign alu_op     = op_q;
  assign mem_rd_req = (state == S_TWAIT);
  assign mem_addr   = mar;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: transaction-level reference model,
// per-cycle compare process, directed and randomized sequences.
module tb_seq_datapath;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [4:0]  op = '0;
  logic [3:0]  ra = '0, rb = '0, rd = '0;
  logic        busy, done, err;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [63:0] alu_c;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [3:0]  dbg_sel = '0;
  logic [31:0] dbg_data, hi, lo;

  seq_datapath #(.WIDTH(32), .NREGS(16), .OPW(5)) dut (
    .clk(clk), .clr(clr), .start(start), .mode(mode), .op(op),
    .ra(ra), .rb(rb), .rd(rd), .busy(busy), .done(done), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .hi(hi), .lo(lo)
  );

  always #20 clk = ~clk;

  // External ALU: 0 add (zero-extended), 1 unsigned multiply, otherwise xor.
  function automatic logic [63:0] alu_fn(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      5'd0:    return {32'b0, a} + {32'b0, b};
      5'd1:    return {32'b0, a} * {32'b0, b};
      default: return {32'b0, a ^ b};
    endcase
  endfunction

  assign alu_c = alu_fn(alu_op, alu_a, alu_b);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic check_en = 1'b0;

  // Reference model state
  logic [31:0] m_regs [16];
  logic [31:0] m_hi, m_lo, exp_addr;
  logic        exp_err;
  int exp_done_cyc = -100;
  int busy_from = 0, busy_to = -1;
  int req_from = 0, req_to = -1;
  int hl_from = 0, hl_to = -1;
  int last_done_cyc = -1;
  logic        p_we, p_hl;
  logic [3:0]  p_rd;
  logic [31:0] p_val, p_hi, p_lo;

  // Memory responder state
  int          ready_delay = 0;
  int          wcnt = 0;
  logic [31:0] mem_word = '0;
  logic [31:0] last_addr = '0;

  function automatic logic [31:0] rd_model(input logic [3:0] idx);
`ifdef SEQ_DATAPATH_R0_ZERO_EN
    if (idx == 4'd0) return 32'd0;
`endif
    return m_regs[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_hi = '0; m_lo = '0; exp_err = 1'b0; exp_addr = '0;
    exp_done_cyc = -100;
    busy_from = 0; busy_to = -1;
    req_from = 0; req_to = -1;
    hl_from = 0; hl_to = -1;
    p_we = 1'b0; p_hl = 1'b0; p_rd = '0; p_val = '0; p_hi = '0; p_lo = '0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rd_req) begin
      if (wcnt >= ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word;
        last_addr = mem_addr;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      mem_ready = 1'($urandom % 2);
      mem_rdata = $urandom;
    end
  end

  // Per-cycle compare against the model; pending results land in the done cycle.
  always @(posedge clk) begin
    #2;
    if (check_en) begin
      if (cyc == exp_done_cyc) begin
        if (p_we) m_regs[p_rd] = p_val;
        if (p_hl) begin m_hi = p_hi; m_lo = p_lo; end
      end
      if (done) last_done_cyc = cyc;
      checkOutput("done", 64'(done), 64'(cyc == exp_done_cyc));
      checkOutput("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
      checkOutput("err", 64'(err), 64'(exp_err));
      checkOutput("mem_rd_req", 64'(mem_rd_req), 64'(cyc >= req_from && cyc <= req_to));
      if (cyc >= req_from && cyc <= req_to) checkOutput("mem_addr", 64'(mem_addr), 64'(exp_addr));
      if (!(cyc >= hl_from && cyc <= hl_to)) begin
        checkOutput("hi", 64'(hi), 64'(m_hi));
        checkOutput("lo", 64'(lo), 64'(m_lo));
      end
    end
  end

  task automatic sweepRegs();
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      checkOutput($sformatf("reg%0d", i), 64'(dbg_data), 64'(rd_model(4'(i))));
    end
  endtask

  // Called at a negedge with the DUT idle or in its done cycle; returns at
  // the negedge of the expected done cycle with n = cycle after accept.
  task automatic applyStimulus(input logic [1:0] m, input logic [4:0] o, input logic [3:0] a,
                               input logic [3:0] b, input logic [3:0] d, input int dly,
                               input logic [31:0] word, output int n);
    int l;
    logic [63:0] res;
    mode = m; op = o; ra = a; rb = b; rd = d;
    ready_delay = dly; mem_word = word; start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    l = (m == 2'd0) ? 3 : (m == 2'd1) ? 4 : (m == 2'd2) ? 3 + dly : 1;
    start = 1'b0;
    exp_err = (m == 2'd3);
    exp_done_cyc = n + l;
    busy_from = n;
    busy_to = (m == 2'd3) ? n - 1 : n + l - 1;
    req_from = (m == 2'd2) ? n + 1 : 0;
    req_to = (m == 2'd2) ? n + 1 + dly : -1;
    exp_addr = rd_model(b);
    hl_from = (m == 2'd1) ? n : 0;
    hl_to = (m == 2'd1) ? n + 3 : -1;
    res = alu_fn(o, rd_model(a), rd_model(b));
    p_rd = d;
    p_we = (m == 2'd0) || (m == 2'd2);
    p_val = (m == 2'd2) ? word : res[31:0];
    p_hl = (m == 2'd1);
    p_hi = res[63:32];
    p_lo = res[31:0];
    for (int i = 0; i < l; i++) begin
      @(negedge clk);
      if (m != 2'd3) begin
        start = 1'($urandom % 2);
        mode = 2'($urandom);
        op = 5'($urandom);
        ra = 4'($urandom); rb = 4'($urandom); rd = 4'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    sweepRegs();
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    int n;
    applyStimulus(2'd2, 5'd0, 4'd0, 4'd0, idx, 0, val, n);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check_en = 1'b1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_req", 64'(mem_rd_req), 64'd0);
    sweepRegs();
    @(negedge clk);

    // Register-to-register add
    preload(4'd2, 32'd7);
    preload(4'd3, 32'd5);
    applyStimulus(2'd0, 5'd0, 4'd2, 4'd3, 4'd4, 0, 32'd0, n);
    checkOutput("lat_mode0", 64'(last_done_cyc - n), 64'd3);
    dbg_sel = 4'd4; #1;
    checkOutput("r4_sum", 64'(dbg_data), 64'd12);
    @(negedge clk);

    // Wide multiply then a back-to-back add in the done cycle
    preload(4'd2, 32'h0001_0000);
    preload(4'd3, 32'h0003_0000);
    applyStimulus(2'd1, 5'd1, 4'd2, 4'd3, 4'd9, 0, 32'd0, n);
    checkOutput("lat_mode1", 64'(last_done_cyc - n), 64'd4);
    checkOutput("hi_lit", 64'(hi), 64'h3);
    checkOutput("lo_lit", 64'(lo), 64'h0);
    applyStimulus(2'd0, 5'd0, 4'd2, 4'd3, 4'd7, 0, 32'd0, n);
    dbg_sel = 4'd7; #1;
    checkOutput("r7_b2b", 64'(dbg_data), 64'h0004_0000);
    @(negedge clk);

    // Load with three wait cycles
    preload(4'd5, 32'h100);
    applyStimulus(2'd2, 5'd0, 4'd0, 4'd5, 4'd6, 3, 32'hDEAD_BEEF, n);
    checkOutput("lat_mode2", 64'(last_done_cyc - n), 64'd6);
    checkOutput("addr_lit", 64'(last_addr), 64'h100);
    dbg_sel = 4'd6; #1;
    checkOutput("r6_load", 64'(dbg_data), 64'hDEAD_BEEF);
    @(negedge clk);

    // Illegal mode, then a legal one clears err
    applyStimulus(2'd3, 5'd0, 4'd1, 4'd1, 4'd1, 0, 32'd0, n);
    checkOutput("lat_mode3", 64'(last_done_cyc - n), 64'd1);
    checkOutput("err_lit", 64'(err), 64'd1);
    applyStimulus(2'd0, 5'd2, 4'd6, 4'd5, 4'd8, 0, 32'd0, n);
    @(negedge clk);

    // Write to R0
    preload(4'd0, 32'h55);
    dbg_sel = 4'd0; #1;
`ifdef SEQ_DATAPATH_R0_ZERO_EN
    checkOutput("r0_zero", 64'(dbg_data), 64'd0);
`else
    checkOutput("r0_write", 64'(dbg_data), 64'h55);
`endif
    @(negedge clk);

    // Randomized sequences, some back-to-back
    for (int k = 0; k < 40; k++) begin
      applyStimulus(2'($urandom % 4), 5'($urandom % 3), 4'($urandom), 4'($urandom),
                    4'($urandom), int'($urandom % 4), $urandom, n);
      repeat ($urandom % 3) @(negedge clk);
    end

    // clr during TB of an add: result dropped, no done
    preload(4'd10, 32'd20);
    mode = 2'd0; op = 5'd0; ra = 4'd10; rb = 4'd10; rd = 4'd11; start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    start = 1'b0;
    exp_err = 1'b0;
    exp_done_cyc = n + 3;
    busy_from = n; busy_to = n + 2;
    req_from = 0; req_to = -1;
    hl_from = 0; hl_to = -1;
    p_we = 1'b1; p_rd = 4'd11; p_val = 32'd40; p_hl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    #1 clr = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("clr_no_done", 64'(last_done_cyc < n), 64'd1);
    sweepRegs();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised bus-based CPU datapath with a built-in micro-step sequencer. Holds the general register file, Y, Z (high/low), HI, LO, MAR and MDR on one internal bus, and runs complete register-to-register ALU, wide-result (HI/LO) and memory-load sequences from a single `start` handshake, replacing per-signal testbench control. The ALU stays external and purely combinational; memory is reached through a ready-qualified read port.

## Interface
- `WIDTH`, 32: data/bus width.
- `NREGS`, 16: general registers; power of two, ≥4. `RW = $clog2(NREGS)`.
- `OPW`, 5: ALU opcode width.

Ports:
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `start` in 1: request a sequence; accepted only when `busy`=0.
- `mode` in 2: 0 ALU→`rd`, 1 ALU wide→HI/LO, 2 load `rd`←mem[`rb`], 3 illegal.
- `op` in OPW: ALU opcode, passed through.
- `ra`, `rb`, `rd` in RW: register indices.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: last accepted start had `mode`=3.
- `alu_a`, `alu_b` out WIDTH; `alu_op` out OPW; `alu_c` in 2·WIDTH: external ALU.
- `mem_rd_req` out 1; `mem_addr` out WIDTH; `mem_rdata` in WIDTH; `mem_ready` in 1.
- `dbg_sel` in RW; `dbg_data` out WIDTH: combinational register read.
- `hi`, `lo` out WIDTH: HI/LO contents.

## Operation
- On accept (`start` && !`busy`): latch `mode`, `op`, `ra`, `rb`, `rd`. Later input changes have no effect. Set `err`=(`mode`==3) and clear it otherwise.
- States: IDLE, TA, TB, TWB, THI, TMAR, TWAIT, TMDR.
- ALU path: TA (bus=R[ra], Y←bus) → TB (`alu_a`=Y, `alu_b`=bus=R[rb], `alu_op`=op, Z←`alu_c`) → TWB (bus=Zlo).
  - Mode 0: R[rd]←bus in TWB, then IDLE.
  - Mode 1: LO←bus in TWB → THI (bus=Zhi, HI←bus) → IDLE.
- Load path: TMAR (bus=R[rb], MAR←bus) → TWAIT (`mem_rd_req`=1, `mem_addr`=MAR; on `mem_ready`, MDR←`mem_rdata`, go TMDR; else stay) → TMDR (bus=MDR, R[rd]←bus) → IDLE.
- Mode 3: IDLE→IDLE. `done` pulses with no register write.
- Exactly one bus source per state. In IDLE the bus is 0 and no register loads.
- `ra`==`rb`, `rd`==`ra`, or `rd`==`rb` is legal. Y captures the operand before any write.
- `start` while `busy` is ignored, with no error.

## Timing
- Reset values: all registers, Y, Z, HI, LO, MAR and MDR are 0. State is IDLE. `busy`, `done`, `err` and `mem_rd_req` are 0.
- `busy` is high from the cycle after the accepting edge until the final-state edge.
- `done` is registered and high for exactly one cycle after the final write edge. The written value is visible in that same cycle.
- Latency from the accepting edge to `done`:
  - Mode 0: 3 cycles.
  - Mode 1: 4 cycles.
  - Mode 2: 3 + (extra TWAIT cycles).
  - Mode 3: 1 cycle.
- A new `start` is accepted in the cycle `done` is high, so sequences run back-to-back.
- `mem_ready` outside TWAIT is ignored. `mem_rd_req` is registered-state decoded and stays stable while waiting.
- `clr` mid-sequence: immediate return to IDLE. Any write not yet clocked is dropped and no `done` is produced.

## Configuration
- `SEQ_DATAPATH_R0_ZERO_EN` defined:
  - R0 always reads 0, including on `dbg_data`.
  - Writes to R0 are discarded; `done` still pulses.
- Undefined: R0 is an ordinary register.

## Structure
- `datapath_pkg`: state enum, mode encodings (`MODE_ALU`, `MODE_WIDE`, `MODE_LOAD`, `MODE_ILL`), and a bus-source select enum.
- Sub-module `dp_regfile`: NREGS×WIDTH, one write port, two read ports (bus, debug), async clear. It honours `SEQ_DATAPATH_R0_ZERO_EN`.
- Sequencer, bus mux, Y/Z/HI/LO/MAR/MDR are in the top level.

## Test plan
Bench ALU model: op 0 = add (zero-extended into 2·WIDTH), op 1 = unsigned multiply.
- Reset, then `dbg_sel` sweep → every register reads 0; `busy`/`done`/`err`/`mem_rd_req` are 0.
- Preload R2=7, R3=5; start mode 0, op 0, ra 2, rb 3, rd 4 → `done` 3 cycles after accept, R4=12, R2/R3 unchanged.
- R2=0x0001_0000, R3=0x0003_0000; mode 1, op 1 → after 4 cycles HI=0x0000_0003, LO=0; back-to-back start in the `done` cycle is accepted.
- Mode 2, R5=0x100 as rb, rd 6; memory holds `mem_ready` low 3 cycles then returns 0xDEADBEEF → `mem_addr`=0x100 throughout the wait, R6=0xDEADBEEF, `done` 6 cycles after accept.
- Mode 3 → `err`=1, `done` after 1 cycle, no register changes; the next legal start clears `err`.
- `clr` pulsed during TB of a mode 0 op → R[rd] unchanged, no `done`. With the macro defined, a write to R0 leaves `dbg_data`=0.
